// File: rtl/fan_if.sv
// Key-pulse and state-field bundle between the keypad front end and the fan controller.
// key_pulse carries one-cycle key requests with no backpressure; key_ack is a one-cycle
// response on the edge after a key is accepted, and a dropped key never gets an ack.
interface fan_if;
  logic [4:0] key_pulse;
  logic       power_on;
  logic [1:0] speed_set;
  logic [1:0] mode;
  logic       shake_en;
  logic [2:0] timer_steps;
  logic [1:0] eff_speed;
  logic       key_ack;
  logic       fsm_state;

  modport master (
    output key_pulse,
    input  power_on, speed_set, mode, shake_en, timer_steps, eff_speed, key_ack, fsm_state
  );

  modport slave (
    input  key_pulse,
    output power_on, speed_set, mode, shake_en, timer_steps, eff_speed, key_ack, fsm_state
  );
endinterface

// File: rtl/fan_mode_ctrl.sv
// Fan controller: arbitrates key pulses and sequences power, speed, mode, oscillation
// and the off-timer, driving the effective motor speed and the display state fields.
module fan_mode_ctrl #(
  parameter int TICKS_PER_SEC    = 1000,
  parameter int TIMER_STEP_SEC   = 1800,
  parameter int NAT_PERIOD_SEC   = 4,
  parameter int SLEEP_PERIOD_SEC = 600
) (
  input  logic clk,
  input  logic rst_n,
  fan_if.slave bus
);
  localparam int PW = (TICKS_PER_SEC    > 1) ? $clog2(TICKS_PER_SEC)    : 1;
  localparam int SW = (TIMER_STEP_SEC   > 1) ? $clog2(TIMER_STEP_SEC)   : 1;
  localparam int NW = (NAT_PERIOD_SEC   > 1) ? $clog2(NAT_PERIOD_SEC)   : 1;
  localparam int LW = (SLEEP_PERIOD_SEC > 1) ? $clog2(SLEEP_PERIOD_SEC) : 1;
  localparam logic [PW-1:0] P_TC = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] S_TC = SW'(TIMER_STEP_SEC - 1);
  localparam logic [NW-1:0] N_TC = NW'(NAT_PERIOD_SEC - 1);
  localparam logic [LW-1:0] L_TC = LW'(SLEEP_PERIOD_SEC - 1);

  typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, n_state;
  logic [1:0]      speed_q, n_speed, mode_q, n_mode, eff_q, n_eff, lvl_q, n_lvl;
  logic            shake_q, n_shake, ack_q, n_ack, phase_q, n_phase;
  logic [2:0]      steps_q, n_steps;
  logic [PW-1:0]   presc_q, n_presc;
  logic [SW-1:0]   step_q, n_step;
  logic [NW-1:0]   nat_q, n_nat;
  logic [LW-1:0]   sleep_q, n_sleep;
  logic            k_power, k_speed, k_mode, k_timer, k_shake;
  logic            sec_tick, step_wrap, expire, clear, restart;

  // Lowest set index wins; higher keys in the same cycle are dropped.
  assign k_power = bus.key_pulse[0];
  assign k_speed = bus.key_pulse[1] & ~bus.key_pulse[0];
  assign k_mode  = bus.key_pulse[2] & ~|bus.key_pulse[1:0];
  assign k_timer = bus.key_pulse[3] & ~|bus.key_pulse[2:0];
  assign k_shake = bus.key_pulse[4] & ~|bus.key_pulse[3:0];

  assign sec_tick  = (state == S_RUN) && (presc_q == P_TC);
  assign step_wrap = sec_tick && (steps_q != 3'd0) && (step_q == S_TC);
  assign expire    = step_wrap && (steps_q == 3'd1);

  always_comb begin
    n_state = state;
    n_speed = speed_q;
    n_mode  = mode_q;
    n_shake = shake_q;
    n_steps = steps_q;
    n_presc = presc_q;
    n_step  = step_q;
    n_nat   = nat_q;
    n_phase = phase_q;
    n_sleep = sleep_q;
    n_lvl   = lvl_q;
    n_ack   = 1'b0;
    clear   = 1'b0;
    restart = 1'b0;
    if (state == S_OFF) begin
      if (k_power) begin
        n_state = S_RUN;
        n_speed = 2'd1;
        n_lvl   = 2'd1;
        n_ack   = 1'b1;
      end
    end else if (expire) begin
      clear = 1'b1;
    end else begin
      n_presc = sec_tick ? '0 : presc_q + 1'b1;
      if (sec_tick && (steps_q != 3'd0)) begin
        if (step_wrap) begin
          n_step  = '0;
          n_steps = steps_q - 3'd1;
        end else begin
          n_step = step_q + 1'b1;
        end
      end
      if (sec_tick && (mode_q == 2'd1)) begin
        n_nat = (nat_q == N_TC) ? '0 : nat_q + 1'b1;
        if (nat_q == N_TC) n_phase = ~phase_q;
      end
      if (sec_tick && (mode_q == 2'd2)) begin
        n_sleep = (sleep_q == L_TC) ? '0 : sleep_q + 1'b1;
        if ((sleep_q == L_TC) && (lvl_q > 2'd1)) n_lvl = lvl_q - 2'd1;
      end
      n_ack = k_power | k_speed | k_mode | k_timer | k_shake;
      if (k_power) clear = 1'b1;
      if (k_speed) begin
        n_speed = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
        restart = 1'b1;
      end
      if (k_mode) begin
        n_mode  = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
        restart = 1'b1;
      end
      // A timer key overrides a same-cycle step decrement: advance from the old count.
      if (k_timer) begin
        n_steps = (steps_q == 3'd4) ? 3'd0 : steps_q + 3'd1;
        n_step  = '0;
      end
      if (k_shake) n_shake = ~shake_q;
      if (restart) begin
        n_nat   = '0;
        n_phase = 1'b0;
        n_sleep = '0;
        n_lvl   = n_speed;
      end
    end
    if (clear) begin
      n_state = S_OFF;
      n_speed = 2'd0;
      n_mode  = 2'd0;
      n_shake = 1'b0;
      n_steps = 3'd0;
      n_presc = '0;
      n_step  = '0;
      n_nat   = '0;
      n_phase = 1'b0;
      n_sleep = '0;
      n_lvl   = 2'd0;
    end
    if (n_state == S_OFF)       n_eff = 2'd0;
    else if (n_mode == 2'd1)    n_eff = n_phase ? 2'd1 : n_speed;
    else if (n_mode == 2'd2)    n_eff = n_lvl;
    else                        n_eff = n_speed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OFF;
      speed_q <= 2'd0;
      mode_q  <= 2'd0;
      shake_q <= 1'b0;
      steps_q <= 3'd0;
      eff_q   <= 2'd0;
      ack_q   <= 1'b0;
      presc_q <= '0;
      step_q  <= '0;
      nat_q   <= '0;
      phase_q <= 1'b0;
      sleep_q <= '0;
      lvl_q   <= 2'd0;
    end else begin
      state   <= n_state;
      speed_q <= n_speed;
      mode_q  <= n_mode;
      shake_q <= n_shake;
      steps_q <= n_steps;
      eff_q   <= n_eff;
      ack_q   <= n_ack;
      presc_q <= n_presc;
      step_q  <= n_step;
      nat_q   <= n_nat;
      phase_q <= n_phase;
      sleep_q <= n_sleep;
      lvl_q   <= n_lvl;
    end
  end

  assign bus.power_on    = (state == S_RUN);
  assign bus.fsm_state   = state;
  assign bus.speed_set   = speed_q;
  assign bus.mode        = mode_q;
  assign bus.shake_en    = shake_q;
  assign bus.timer_steps = steps_q;
  assign bus.eff_speed   = eff_q;
  assign bus.key_ack     = ack_q;
endmodule
